pic_inta_sequencer: RTL

Synchronous controller that runs the 8259 interrupt-acknowledge sequence around the in-service register. It resolves priority among pending unmasked requests, asserts INT, and sequences the two INTA pulses: it sets ISR on the first pulse and drives the vector on the second. It also executes OCW2 EOI and rotation commands. It sits between the IRR/IMR block, the command decoder and the data-bus driver, and owns ISR and the priority-rotation state.

---
 rtl/pic_inta_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pic_inta_sequencer.sv
// 8259-style interrupt-acknowledge sequencer: resolves rotating priority against the
// in-service register, runs the two-pulse INTA handshake and executes OCW2 EOI/rotation.
module pic_inta_sequencer #(
  parameter int NUM_IR       = 8,
  parameter int SPURIOUS_IDX = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] imr,
  input  logic              inta_n,
  input  logic              aeoi,
  input  logic [4:0]        vector_base,
  input  logic              ocw2_valid,
  input  logic [2:0]        ocw2_cmd,
  input  logic [2:0]        ocw2_level,
  output logic              int_out,
  output logic [NUM_IR-1:0] isr,
  output logic [NUM_IR-1:0] irr_clear,
  output logic [7:0]        vec_out,
  output logic              vec_valid,
  output logic [2:0]        lowest_prio
);

  typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

  localparam logic [NUM_IR-1:0] ONE_HOT0 = NUM_IR'(1);

  state_t            state, state_nxt;
  logic              inta_prev;
  logic              inta_fall, inta_rise;
  logic              rotate_aeoi;
  logic [2:0]        ack_idx;
  logic              ack_spurious;

  logic [NUM_IR-1:0] req;
  logic [2:0]        lvl;
  logic              win_found, isr_found, eligible;
  logic [2:0]        win_idx, isr_idx;
  logic [3:0]        win_rank, isr_rank;

  logic              take_ack1, finish_ack2;
  logic [NUM_IR-1:0] isr_set, ocw_clr, aeoi_clr, isr_nxt;
  logic              ocw_lp_we, ocw_rot_we, ocw_rot_val;
  logic [2:0]        ocw_lp_val;
  logic              aeoi_lp_we;

  assign inta_fall = inta_prev & ~inta_n;
  assign inta_rise = ~inta_prev & inta_n;
  assign req       = irr & ~imr;

  // Walk levels from lowest_prio+1 upward; the first hit in each vector is its top priority.
  always_comb begin
    lvl       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_rank  = 4'd8;
    isr_found = 1'b0;
    isr_idx   = '0;
    isr_rank  = 4'd8;
    for (int k = 0; k < NUM_IR; k++) begin
      lvl = lowest_prio + 3'd1 + 3'(k);
      if (!win_found && req[lvl]) begin
        win_found = 1'b1;
        win_idx   = lvl;
        win_rank  = 4'(k);
      end
      if (!isr_found && isr[lvl]) begin
        isr_found = 1'b1;
        isr_idx   = lvl;
        isr_rank  = 4'(k);
      end
    end
    eligible = win_found && (win_rank < isr_rank);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inta_fall) state_nxt = ACK1;
      ACK1:    if (inta_rise) state_nxt = GAP;
      GAP:     if (inta_fall) state_nxt = ACK2;
      ACK2:    if (inta_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    take_ack1   = (state == IDLE) && inta_fall;
    finish_ack2 = (state == ACK2) && inta_rise;
    vec_valid   = (state == ACK2);
    vec_out     = vec_valid ? {vector_base, ack_idx} : 8'h00;
  end

  always_comb begin
    ocw_clr     = '0;
    ocw_lp_we   = 1'b0;
    ocw_lp_val  = ocw2_level;
    ocw_rot_we  = 1'b0;
    ocw_rot_val = 1'b0;
    if (ocw2_valid) begin
      case (ocw2_cmd)
        3'b001: if (isr_found) ocw_clr = ONE_HOT0 << isr_idx;
        3'b011: ocw_clr = ONE_HOT0 << ocw2_level;
        3'b101: begin
          if (isr_found) begin
            ocw_clr    = ONE_HOT0 << isr_idx;
            ocw_lp_we  = 1'b1;
            ocw_lp_val = isr_idx;
          end
        end
        3'b111: begin
          ocw_clr   = ONE_HOT0 << ocw2_level;
          ocw_lp_we = 1'b1;
        end
        3'b110: ocw_lp_we = 1'b1;
        3'b100: begin
          ocw_rot_we  = 1'b1;
          ocw_rot_val = 1'b1;
        end
        3'b000: ocw_rot_we = 1'b1;
        default: ;
      endcase
    end
  end

  // A same-cycle acknowledge set overrides any EOI clear of that bit.
  always_comb begin
    isr_set    = (take_ack1 && eligible) ? (ONE_HOT0 << win_idx) : '0;
    aeoi_clr   = (finish_ack2 && aeoi && !ack_spurious) ? (ONE_HOT0 << ack_idx) : '0;
    aeoi_lp_we = finish_ack2 && aeoi && !ack_spurious && rotate_aeoi;
    isr_nxt    = (isr & ~(ocw_clr | aeoi_clr)) | isr_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inta_prev    <= 1'b1;
      isr          <= '0;
      irr_clear    <= '0;
      int_out      <= 1'b0;
      ack_idx      <= '0;
      ack_spurious <= 1'b0;
      lowest_prio  <= 3'd7;
      rotate_aeoi  <= 1'b0;
    end else begin
      inta_prev <= inta_n;
      isr       <= isr_nxt;
      irr_clear <= isr_set;
      int_out   <= (state == IDLE) && !inta_fall && eligible;
      if (take_ack1) begin
        ack_idx      <= eligible ? win_idx : 3'(SPURIOUS_IDX);
        ack_spurious <= !eligible;
      end
      if (ocw_lp_we)       lowest_prio <= ocw_lp_val;
      else if (aeoi_lp_we) lowest_prio <= ack_idx;
      if (ocw_rot_we) rotate_aeoi <= ocw_rot_val;
    end
  end

endmodule
